// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller:
// memory-wait FSM states and forwarding select codes.
package hazard_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam logic [1:0] RES_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_fwd.sv
// One ALU operand forwarding selector; the younger M-stage
// result wins over the W-stage result.
module fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic       reg_write_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_w,
    output logic [1:0] fwd
);

    always_comb begin
        fwd = FWD_NONE;
        if (reg_write_m && rd_m != 5'd0 && rd_m == rs_e)
            fwd = FWD_MEM;
        else if (reg_write_w && rd_w != 5'd0 && rd_w == rs_e)
            fwd = FWD_WB;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: forwarding, load-use stall,
// branch flush and memory wait with timeout.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic             RegWriteM,
    input  logic [1:0]       ResultSrcM,
    input  logic             MemWriteM,
    input  logic             MemReadyM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCount
);

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    mem_state_t state;
    logic [7:0] wait_cnt;
    logic       lw_stall;
    logic       mem_op;
    logic       mem_stall;
    logic       timeout;

    fwd_unit u_fwd_a (
        .rs_e        (Rs1E),
        .rd_m        (RdM),
        .reg_write_m (RegWriteM),
        .rd_w        (RdW),
        .reg_write_w (RegWriteW),
        .fwd         (ForwardAE)
    );

    fwd_unit u_fwd_b (
        .rs_e        (Rs2E),
        .rd_m        (RdM),
        .reg_write_m (RegWriteM),
        .rd_w        (RdW),
        .reg_write_w (RegWriteW),
        .fwd         (ForwardBE)
    );

    always_comb begin
        lw_stall = (ResultSrcE == RES_LOAD) && (RdE != 5'd0)
                   && ((RdE == Rs1D) || (RdE == Rs2D));
        mem_op   = MemWriteM || (ResultSrcM == RES_LOAD);
        timeout  = (state == WAIT) && !MemReadyM
                   && (wait_cnt >= TIMEOUT);
        if (state == IDLE)
            mem_stall = mem_op && !MemReadyM;
        else
            mem_stall = !MemReadyM && (wait_cnt < TIMEOUT);
    end

    // Reset forces bubbles everywhere; memory stall dominates otherwise.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b1;
        FlushE = 1'b1;
        FlushW = 1'b1;
        if (!rst) begin
            if (mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushD = 1'b0;
                FlushE = 1'b0;
                FlushW = 1'b1;
            end else begin
                StallF = lw_stall;
                StallD = lw_stall;
                FlushE = lw_stall || PCSrcE;
                FlushD = PCSrcE;
                FlushW = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= 8'd0;
            MemErr     <= 1'b0;
            StallCount <= '0;
        end else begin
            if (StallF && (StallCount != {CNT_W{1'b1}}))
                StallCount <= StallCount + CNT_W'(1);
            case (state)
                IDLE: begin
                    if (mem_op && !MemReadyM) begin
                        state    <= WAIT;
                        wait_cnt <= 8'd0;
                    end
                end
                WAIT: begin
                    if (MemReadyM) begin
                        state <= IDLE;
                    end else if (timeout) begin
                        state  <= IDLE;
                        MemErr <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then
// random traffic against a behavioural reference model.
module tb_hazard_ctrl;

    localparam int TMO     = 4;
    localparam int CW      = 6;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]    ResultSrcE, ResultSrcM;
    logic          PCSrcE, RegWriteM, MemWriteM, MemReadyM, RegWriteW;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, StallM;
    logic          FlushD, FlushE, FlushW, MemErr;
    logic [CW-1:0] StallCount;

    hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .MemWriteM(MemWriteM), .MemReadyM(MemReadyM),
        .RdW(RdW), .RegWriteW(RegWriteW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE),
        .FlushW(FlushW), .MemErr(MemErr), .StallCount(StallCount)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [1:0]    fa;
        logic [1:0]    fb;
        logic [6:0]    ctl;
        logic          err;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference state: m_wait < 0 means no access outstanding,
    // otherwise the number of extra cycles already waited.
    int   m_wait = -1;
    bit   m_err  = 0;
    int   m_cnt  = 0;

    function automatic logic [1:0] fwd_of(logic [4:0] rs);
        if (rs != 0 && RegWriteM && RdM == rs) return 2'b10;
        if (rs != 0 && RegWriteW && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit mem_busy();
        bit op;
        op = MemWriteM || ResultSrcM == 2'b01;
        if (m_wait < 0) return op && !MemReadyM;
        return !MemReadyM && m_wait < TMO;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        bit lw, ms;
        lw = ResultSrcE == 2'b01 && RdE != 0
             && (RdE == Rs1D || RdE == Rs2D);
        ms = mem_busy();
        e.fa  = fwd_of(Rs1E);
        e.fb  = fwd_of(Rs2E);
        e.err = m_err;
        e.cnt = CW'(m_cnt);
        if (rst)     e.ctl = 7'b0000_111;
        else if (ms) e.ctl = 7'b1111_001;
        else e.ctl = {lw, lw, 1'b0, 1'b0, PCSrcE, lw | PCSrcE, 1'b0};
        return e;
    endfunction

    function automatic void advance(bit sf);
        bit op;
        op = MemWriteM || ResultSrcM == 2'b01;
        if (sf) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        if (m_wait < 0) begin
            if (op && !MemReadyM) m_wait = 0;
        end else if (MemReadyM) begin
            m_wait = -1;
        end else if (m_wait >= TMO) begin
            m_err  = 1;
            m_wait = -1;
        end else begin
            m_wait = m_wait + 1;
        end
    endfunction

    task automatic cycle();
        exp_t e;
        if (rst) begin
            m_wait = -1;
            m_err  = 0;
            m_cnt  = 0;
        end
        e = predict();
        q.push_back(e);
        @(posedge clk);
        if (!rst) advance(e.ctl[6]);
        #1;
    endtask

    task automatic check(string n, logic [7:0] got, logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", n, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("fwd", {ForwardAE, ForwardBE}, {e.fa, e.fb});
            check("ctl", {1'b0, StallF, StallD, StallE, StallM,
                          FlushD, FlushE, FlushW}, {1'b0, e.ctl});
            check("err", {7'd0, MemErr}, {7'd0, e.err});
            check("cnt", 8'(StallCount), 8'(e.cnt));
        end
    end

    task automatic quiet();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {ResultSrcE, ResultSrcM} = '0;
        {PCSrcE, RegWriteM, MemWriteM, RegWriteW} = '0;
        MemReadyM = 1'b1;
    endtask

    task automatic rand_inputs();
        Rs1D       = 5'($urandom_range(0, 3));
        Rs2D       = 5'($urandom_range(0, 3));
        Rs1E       = 5'($urandom_range(0, 3));
        Rs2E       = 5'($urandom_range(0, 3));
        RdE        = 5'($urandom_range(0, 3));
        RdM        = 5'($urandom_range(0, 3));
        RdW        = 5'($urandom_range(0, 3));
        ResultSrcE = 2'($urandom_range(0, 3));
        ResultSrcM = 2'($urandom_range(0, 3));
        PCSrcE     = ($urandom_range(0, 7) == 0);
        RegWriteM  = 1'($urandom_range(0, 1));
        RegWriteW  = 1'($urandom_range(0, 1));
        MemWriteM  = ($urandom_range(0, 5) == 0);
        MemReadyM  = ($urandom_range(0, 99) < 45);
        rst        = ($urandom_range(0, 299) == 0);
    endtask

    initial begin
        #2;
        quiet();
        rst = 1'b1;
        #3;
        check("rst_flush", {5'd0, FlushD, FlushE, FlushW}, 8'h07);
        check("rst_stall", {7'd0, StallF}, 8'h00);
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5;
        #3 check("fwd_mem", 8'(ForwardAE), 8'h02);
        cycle();
        RdM = 0;
        #3 check("fwd_wb", 8'(ForwardAE), 8'h01);
        cycle();
        Rs1E = 0;
        #3 check("fwd_x0", 8'(ForwardAE), 8'h00);
        cycle();
        quiet();

        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        #3 check("lw_stall", {5'd0, StallF, StallD, FlushE}, 8'h07);
        cycle();
        quiet();
        #3 check("lw_one", {7'd0, StallF}, 8'h00);
        check("lw_cnt", 8'(StallCount), 8'h01);
        cycle();

        PCSrcE = 1;
        #3 check("br_flush", {5'd0, FlushD, FlushE, StallF}, 8'h06);
        cycle();
        quiet();

        MemWriteM = 1; MemReadyM = 0;
        for (int i = 0; i < 3; i++) begin
            #3 check("mw_stall", {4'd0, StallF, StallM, FlushW, FlushD},
                     8'h0e);
            cycle();
        end
        MemReadyM = 1;
        #3 check("mw_rel", {6'd0, StallF, MemErr}, 8'h00);
        cycle();
        quiet();
        cycle();

        ResultSrcM = 2'b01; MemReadyM = 0;
        for (int i = 0; i <= TMO; i++) cycle();
        #3 check("tmo_rel", {6'd0, StallF, MemErr}, 8'h00);
        cycle();
        quiet();
        #3 check("tmo_err", {7'd0, MemErr}, 8'h01);
        cycle();
        cycle();
        #3 check("err_sticky", {7'd0, MemErr}, 8'h01);
        cycle();

        MemWriteM = 1; MemReadyM = 0;
        cycle();
        cycle();
        rst = 1'b1;
        #3 check("rstw_drop", {4'd0, StallF, FlushD, FlushE, FlushW},
                 8'h07);
        cycle();
        rst = 1'b0;
        quiet();
        #3 check("rstw_cnt", {StallCount, 1'b0, StallF}, 8'h00);
        cycle();

        MemWriteM = 1;
        #3 check("zero_wait", {7'd0, StallF}, 8'h00);
        cycle();
        quiet();

        ResultSrcM = 2'b01; MemReadyM = 0;
        for (int i = 0; i < 100; i++) cycle();
        quiet();
        #3 check("cnt_sat", 8'(StallCount), 8'(CNT_MAX));
        cycle();

        for (int i = 0; i < 2000; i++) begin
            rand_inputs();
            cycle();
        end
        quiet();
        rst = 1'b0;
        cycle();

        @(negedge clk);
        #1;
        check("sb_drain", 8'(q.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
